// File: rtl/idex_plr.sv
// ID/EX pipeline register with load-use hazard detection, flush/halt bubble
// insertion and a saturating count of hazard bubbles.
module idex_plr #(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_Rs,
  input  logic [RW-1:0] id_Rt,
  input  logic [RW-1:0] id_WR,
  input  logic          id_usesRs,
  input  logic          id_usesRt,
  input  logic          id_RegWrite,
  input  logic          id_MemRead,
  input  logic          id_MemWrite,
  input  logic          id_Halt,
  input  logic [3:0]    id_ALUOp,
  input  logic [DW-1:0] id_RD1,
  input  logic [DW-1:0] id_RD2,
  input  logic [DW-1:0] id_Imm,
  input  logic          flush,
  output logic          Stall,
  output logic          valid_EX,
  output logic [RW-1:0] idexRs,
  output logic [RW-1:0] idexRt,
  output logic [RW-1:0] idex_WR,
  output logic          RegWrite_EX,
  output logic          MemRead_EX,
  output logic          MemWrite_EX,
  output logic          Halt_EX,
  output logic [3:0]    ALUOp_EX,
  output logic [DW-1:0] RD1_EX,
  output logic [DW-1:0] RD2_EX,
  output logic [DW-1:0] Imm_EX,
  output logic          halted,
  output logic [15:0]   bubble_cnt
);

  logic          r_valid;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;
  logic [RW-1:0] r_wr;
  logic          r_regwrite;
  logic          r_memread;
  logic          r_memwrite;
  logic          r_halt;
  logic [3:0]    r_aluop;
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic [DW-1:0] r_imm;
  logic          r_halted;
  logic [15:0]   r_bubble_cnt;

  logic          w_hazard;
  logic          w_load_halt;

  // Load-use hazard: a valid load in EX writes a register the ID instruction reads.
  always_comb begin
    w_hazard = 1'b0;
    if (id_valid && r_valid && r_memread && (r_wr != '0)) begin
      w_hazard = (id_usesRs && (id_Rs == r_wr)) || (id_usesRt && (id_Rt == r_wr));
    end
  end

  assign w_load_halt = id_valid && id_Halt;
  assign Stall       = w_hazard && !flush && !r_halted;

  // Pipeline register update: flush > halted > hazard > normal load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wr         <= '0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_halt       <= 1'b0;
      r_aluop      <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_halted     <= 1'b0;
      r_bubble_cnt <= '0;
    end else if (flush || r_halted || w_hazard) begin
      r_valid    <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_wr       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_halt     <= 1'b0;
      r_aluop    <= '0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      // Only genuine hazard bubbles are counted; flush and halt take precedence.
      if (!flush && !r_halted && (r_bubble_cnt != 16'hFFFF)) begin
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
      end
    end else begin
      r_valid    <= id_valid;
      r_rs       <= id_Rs;
      r_rt       <= id_Rt;
      r_wr       <= id_WR;
      r_regwrite <= id_valid && id_RegWrite;
      r_memread  <= id_valid && id_MemRead;
      r_memwrite <= id_valid && id_MemWrite;
      r_halt     <= w_load_halt;
      r_aluop    <= id_valid ? id_ALUOp : 4'd0;
      r_rd1      <= id_RD1;
      r_rd2      <= id_RD2;
      r_imm      <= id_Imm;
      if (w_load_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign valid_EX    = r_valid;
  assign idexRs      = r_rs;
  assign idexRt      = r_rt;
  assign idex_WR     = r_wr;
  assign RegWrite_EX = r_regwrite;
  assign MemRead_EX  = r_memread;
  assign MemWrite_EX = r_memwrite;
  assign Halt_EX     = r_halt;
  assign ALUOp_EX    = r_aluop;
  assign RD1_EX      = r_rd1;
  assign RD2_EX      = r_rd2;
  assign Imm_EX      = r_imm;
  assign halted      = r_halted;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: doc/idex_plr.md
# idex_plr

ID/EX pipeline register with integrated load-use hazard detection for the 16-register, 16-bit pipelined CPU. It captures decoded operands and control from the ID stage each cycle. It produces the `idexRs`/`idexRt`/`idex_WR` fields and EX-stage control that the forwarding unit and ALU consume. It also inserts bubbles on load-use hazards, branch flushes and after a halt, and counts hazard bubbles.

## Interface
Parameters:
- DW, 16, datapath width
- RW, 4, register-address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_Rs, id_Rt, id_WR  in  RW  source 1, source 2 and destination register addresses
- id_usesRs, id_usesRt  in  1  instruction actually reads Rs / Rt
- id_RegWrite, id_MemRead, id_MemWrite, id_Halt  in  1  decoded control
- id_ALUOp  in  4  ALU operation
- id_RD1, id_RD2, id_Imm  in  DW  register-file read data and sign-extended immediate
- flush  in  1  branch taken, squash the instruction in ID
- Stall  out  1  hold PC and IF/ID this cycle (combinational)
- valid_EX  out  1  EX holds a real instruction
- idexRs, idexRt, idex_WR  out  RW  registered addresses
- RegWrite_EX, MemRead_EX, MemWrite_EX, Halt_EX  out  1  registered control
- ALUOp_EX  out  4  registered ALU operation
- RD1_EX, RD2_EX, Imm_EX  out  DW  registered data
- halted  out  1  halt latched; pipeline frozen to bubbles
- bubble_cnt  out  16  saturating count of hazard bubbles

## Operation
- Hazard (combinational) is true when all of the following hold:
  - `id_valid`, `valid_EX` and `MemRead_EX` are all 1.
  - `idex_WR != 0`.
  - Either (`id_usesRs` and `id_Rs == idex_WR`) or (`id_usesRt` and `id_Rt == idex_WR`).
- `Stall` = hazard AND NOT flush AND NOT halted.
- Bubble: all registered outputs loaded with 0. `valid_EX`, control, addresses and data are all 0. Register 0 is never forwarded.
- Next-state priority, evaluated each rising edge:
  1. `flush` → load bubble. Hazard and `id_Halt` are ignored.
  2. `halted` → load bubble.
  3. Hazard → load bubble; `bubble_cnt` += 1, saturating at 0xFFFF.
  4. Otherwise → load all `id_*` fields. `valid_EX` = `id_valid`. If `id_valid` = 0, control fields load 0.
- Halt: when case 4 loads an instruction with `id_valid` = 1 and `id_Halt` = 1:
  - `Halt_EX` = 1 for that one instruction.
  - `halted` sets on the same edge.
  - `halted` clears only on reset.
- Flush never increments `bubble_cnt`. Halted bubbles never increment it.
- The counter increments only in case 4 → case 3 ordering as given. Exactly one increment per hazard edge.

## Timing
- Reset (`rst_n` = 0, asynchronous): every registered output is 0 immediately, including `halted` and `bubble_cnt`.
- `Stall` = 0 while in reset, because `valid_EX` = 0.
- Release of reset is synchronous to the next rising edge.
- Latency:
  - ID → EX: 1 cycle.
  - `Stall` is same-cycle combinational from current `*_EX` state and `id_*` inputs.
- A load-use pair produces exactly one bubble. On the next cycle `MemRead_EX` = 0, so the hazard drops and the held instruction loads.
- `flush` and hazard in the same cycle: the flush bubble wins, `Stall` = 0, and the counter is unchanged.
- Reset asserted mid-stall: all state clears asynchronously; no pending stall survives.
- `bubble_cnt` at 0xFFFF stays at 0xFFFF.

## Test plan
- Reset: drive random inputs, pulse `rst_n` low mid-cycle → all outputs read 0 before the next edge. `Stall` = 0.
- Load-use:
  - Cycle 0: load `id_WR` = 3, `MemRead` = 1.
  - Cycle 1: ID shows ADD with `id_Rs` = 3, `usesRs` = 1 → `Stall` = 1 in cycle 1; at edge 2 `valid_EX` = 0, `bubble_cnt` = 1.
  - Cycle 2: `Stall` = 0 and the ADD loads, giving `idexRs` = 3.
- Register-0 and unused-source checks:
  - Load to R0 followed by a reader of R0 → no stall.
  - Load to R5 followed by an instruction with `id_Rt` = 5 and `usesRt` = 0 → no stall.
- Flush and hazard together: hazard conditions plus `flush` = 1 → `Stall` = 0, bubble loaded, `bubble_cnt` unchanged.
- Halt:
  - Load a valid instruction with `id_Halt` = 1 → `Halt_EX` = 1 for one cycle and `halted` = 1.
  - Subsequent valid ID instructions → `valid_EX` stays 0 until reset.
  - Repeat with `flush` = 1 on the halt cycle → `halted` stays 0.
- Saturation: force 65,536 hazard bubbles → `bubble_cnt` = 0xFFFF and remains there on further hazards.
